sprite_palette_lut: RTL
=======================

# sprite_palette_lut

Runtime-loadable, multi-palette colour lookup for the sprite renderer. It replaces per-piece fixed palette ROMs with one RAM holding NUM_PAL palettes of 2^IDX_W entries each. Each entry is a packed RGB colour of COLOR_W bits per channel. Each valid pixel index from the sprite fetch stage is mapped to RGB with a fixed 2-cycle latency, plus a transparency flag and an optional highlight brighten, before the VGA compositor.

## Interface
- IDX_W, 4: pixel index width; 2^IDX_W entries per palette.
- NUM_PAL, 12: number of palettes (one per piece type/colour).
- COLOR_W, 4: bits per colour channel.
- TRANSP_IDX, 0: index value reported as transparent.
- HL_ADD, 3: per-channel highlight increment.

Ports:
- Clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel request this cycle.
- pal_sel  in  $clog2(NUM_PAL)  palette select.
- index  in  IDX_W  pixel index.
- highlight  in  1  brighten this pixel.
- wr_en  in  1  palette write request.
- wr_pal  in  $clog2(NUM_PAL)  write palette.
- wr_idx  in  IDX_W  write entry.
- wr_rgb  in  3*COLOR_W  write colour {R,G,B}.
- busy  out  1  init sweep in progress.
- out_valid  out  1  result valid.
- red, green, blue  out  COLOR_W each  result colour.
- transparent  out  1  result is transparent.

## Operation
- FSM states are INIT and RUN. Reset enters INIT with clear counter = 0.
- INIT:
  - Writes zero to entry `counter` each cycle. Address = pal*2^IDX_W + idx, linear over NUM_PAL*2^IDX_W entries.
  - busy=1. pix_valid and wr_en are ignored (dropped, not queued).
  - After the last entry is cleared, go to RUN on the next cycle; busy falls that cycle.
- RUN:
  - wr_en=1 writes wr_rgb into the addressed entry.
  - pix_valid=1 launches a lookup.
- Stage 1: synchronous RAM read, registering pal_sel/index-derived flags, highlight, and valid.
- Stage 2: transform and output register.
- transparent=1 when index==TRANSP_IDX. RGB is still the stored colour, and highlight is not applied.
- Out-of-range pal_sel (>=NUM_PAL): result RGB=0, transparent=1. No RAM access is required.
- Out-of-range wr_pal: write dropped, no entry modified.
- Write-first collision: when a RUN-state write and a lookup hit the same entry in the same cycle, the lookup returns wr_rgb.
- When pix_valid=0, out_valid=0 two cycles later. RGB and transparent hold their previous values.

## Timing
- Latency: pix_valid at cycle N gives out_valid and the result at cycle N+2. Throughput is 1 per cycle, with no backpressure.
- A write at cycle N is visible to lookups issued at N (bypass) and later.
- Reset values: busy=1, out_valid=0, red=green=blue=0, transparent=0. Pipeline valid bits are cleared.
- INIT lasts exactly NUM_PAL*2^IDX_W cycles from the first Clk edge after reset_n deasserts. Default: 192 cycles.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs return to reset values immediately (asynchronous).
  - In-flight pixels are discarded.
  - INIT restarts from entry 0.

## Configuration
- PALETTE_HIGHLIGHT_EN defined:
  - Stage 2 adds HL_ADD to each channel when highlight=1 and the pixel is not transparent.
  - The addition saturates at 2^COLOR_W-1.
- Not defined:
  - The highlight input is ignored and stage 2 passes the RAM colour through unchanged.
  - Latency stays 2 cycles.

## Test plan
- Reset then idle: busy=1 for 192 cycles then 0. A lookup of (pal 3, idx 5) returns RGB 0,0,0 with out_valid 2 cycles later.
- Write (pal 1, idx 6) = {B,0,B}, then look it up: red=B, green=0, blue=B, transparent=0 at N+2. Look up idx 0: transparent=1.
- Same-cycle write of (2,7)={6,6,6} and lookup of (2,7): the result is 6,6,6. A back-to-back stream of 16 indices gives 16 consecutive out_valid cycles, in order.
- With PALETTE_HIGHLIGHT_EN and entry {D,1,0}, highlight=1 gives {F,4,3}. Without the macro it gives {D,1,0}.
- Lookup and write with pal_sel/wr_pal=12 (NUM_PAL=12): output RGB 0 with transparent=1, and no entry changes.
- Assert reset_n low for 1 cycle at INIT count 50 and during a RUN stream: out_valid drops immediately and busy=1. A full 192-cycle sweep reruns, and prior writes read back as 0.

Source files
------------

// File: rtl/sprite_palette_lut.sv
// sprite_palette_lut
//   Runtime-loadable multi-palette colour lookup for the sprite renderer.
//   One RAM holds NUM_PAL palettes of 2^IDX_W packed {R,G,B} entries.
//   After reset an INIT sweep clears every entry (busy=1); afterwards each
//   valid pixel index is mapped to RGB with a fixed 2-cycle latency.
//
//   Optional feature macro: PALETTE_HIGHLIGHT_EN
//     defined     : highlight=1 on a non-transparent pixel adds HL_ADD to each
//                   channel, saturating at 2^COLOR_W-1.
//     not defined : highlight is ignored, RAM colour passes through.
//
// Ports
//   Clk, reset_n        clock (rising edge), asynchronous active-low reset
//   pix_valid, pal_sel, index, highlight   lookup request
//   wr_en, wr_pal, wr_idx, wr_rgb          palette write request
//   busy                INIT sweep in progress
//   out_valid, red, green, blue, transparent   lookup result (N+2)
module sprite_palette_lut #(
  parameter int IDX_W      = 4,
  parameter int NUM_PAL    = 12,
  parameter int COLOR_W    = 4,
  parameter int TRANSP_IDX = 0,
  parameter int HL_ADD     = 3
) (
  input  logic                       Clk,
  input  logic                       reset_n,
  input  logic                       pix_valid,
  input  logic [$clog2(NUM_PAL)-1:0] pal_sel,
  input  logic [IDX_W-1:0]           index,
  input  logic                       highlight,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [3*COLOR_W-1:0]       wr_rgb,
  output logic                       busy,
  output logic                       out_valid,
  output logic [COLOR_W-1:0]         red,
  output logic [COLOR_W-1:0]         green,
  output logic [COLOR_W-1:0]         blue,
  output logic                       transparent
);

  localparam int PAL_W  = $clog2(NUM_PAL);
  localparam int ADDR_W = PAL_W + IDX_W;   // {pal,idx} == pal*2^IDX_W + idx
  localparam int DEPTH  = NUM_PAL * (2 ** IDX_W);
  localparam int RGB_W  = 3 * COLOR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_last;

  logic [RGB_W-1:0]    mem [0:DEPTH-1];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [RGB_W-1:0]    mem_wdata;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_ok;
  logic                lookup;
  logic                rd_pal_ok;
  logic                wr_pal_ok;

  logic                s1_valid;
  logic                s1_transp;
  logic                s1_oor;
  logic [RGB_W-1:0]    s1_rgb;
  logic [COLOR_W-1:0]  s2_r, s2_g, s2_b;
  logic                s2_t;

  assign clr_last  = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign rd_pal_ok = ({1'b0, pal_sel} < (PAL_W + 1)'(NUM_PAL));
  assign wr_pal_ok = ({1'b0, wr_pal}  < (PAL_W + 1)'(NUM_PAL));

  // State register and clear counter
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= (state == INIT && !clr_last) ? clr_cnt + 1'b1 : '0;
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (clr_last) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == INIT);
  end

  // Requests are only honoured in RUN; during INIT they are dropped.
  assign lookup    = pix_valid && (state == RUN);
  assign wr_ok     = wr_en && wr_pal_ok && (state == RUN);
  assign rd_addr   = {pal_sel, index};
  assign mem_we    = busy || wr_ok;
  assign mem_waddr = busy ? clr_cnt : {wr_pal, wr_idx};
  assign mem_wdata = busy ? '0 : wr_rgb;

  // Palette RAM with write-first bypass on a same-cycle, same-entry hit.
  // Out-of-range palettes read whatever; stage 2 forces the result to 0.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (lookup) s1_rgb <= (wr_ok && mem_waddr == rd_addr) ? wr_rgb : mem[rd_addr];
  end

`ifdef PALETTE_HIGHLIGHT_EN
  logic s1_hl;

  function automatic logic [COLOR_W-1:0] brighten(input logic [COLOR_W-1:0] c);
    logic [COLOR_W:0] s;
    s = {1'b0, c} + (COLOR_W + 1)'(HL_ADD);
    return s[COLOR_W] ? '1 : s[COLOR_W-1:0];
  endfunction
`else
  logic unused_highlight;
  assign unused_highlight = highlight;
`endif

  // Stage 1 control
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
      s1_oor    <= 1'b0;
`ifdef PALETTE_HIGHLIGHT_EN
      s1_hl     <= 1'b0;
`endif
    end else begin
      s1_valid  <= lookup;
      s1_transp <= (index == IDX_W'(TRANSP_IDX));
      s1_oor    <= !rd_pal_ok;
`ifdef PALETTE_HIGHLIGHT_EN
      s1_hl     <= highlight;
`endif
    end
  end

  // Stage 2 transform
  always_comb begin
    s2_r = s1_rgb[3*COLOR_W-1:2*COLOR_W];
    s2_g = s1_rgb[2*COLOR_W-1:COLOR_W];
    s2_b = s1_rgb[COLOR_W-1:0];
    s2_t = s1_transp;
    if (s1_oor) begin
      s2_r = '0;
      s2_g = '0;
      s2_b = '0;
      s2_t = 1'b1;
    end
`ifdef PALETTE_HIGHLIGHT_EN
    else if (s1_hl && !s1_transp) begin
      s2_r = brighten(s2_r);
      s2_g = brighten(s2_g);
      s2_b = brighten(s2_b);
    end
`endif
  end

  // Output register; colour holds when no result is produced.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        red         <= s2_r;
        green       <= s2_g;
        blue        <= s2_b;
        transparent <= s2_t;
      end
    end
  end

endmodule
